// File: rtl/pagerank_sched.sv
// rtl/pagerank_sched.sv - PageRank iteration scheduler sequencing clear/MAC/commit over a latched adjacency matrix
module pagerank_sched #(
  parameter int N        = 16,
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 32,
  parameter logic [WIDTH-1:0] EPS = WIDTH'(16'h0010)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N*N-1:0]         adjacency,
  input  logic                   mac_ack,
  input  logic [WIDTH-1:0]       delta,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [$clog2(N)-1:0]   row_idx,
  output logic [$clog2(N)-1:0]   col_idx,
  output logic                   acc_clr,
  output logic                   mac_req,
  output logic                   commit,
  output logic [7:0]             iter_count
);

  localparam int LN = $clog2(N);
  localparam logic [LN-1:0] LAST_IDX = LN'(N - 1);
  localparam logic [7:0]    ITER_LIM = 8'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SCAN   = 3'd2,
    COMMIT = 3'd3,
    CHECK  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t           r_state;
  logic [N*N-1:0]   r_adj;
  logic [LN-1:0]    r_row;
  logic [LN-1:0]    r_col;
  logic [7:0]       r_iter;
  logic [WIDTH-1:0] r_max;
  logic             r_busy;
  logic             r_done;
  logic             r_conv;
  logic             r_acc_clr;
  logic             r_mac_req;
  logic             r_commit;

  logic [LN-1:0]    w_col_nxt;
  logic             w_elig_first;
  logic             w_elig_nxt;
  logic             w_last_col;
  logic             w_last_row;
  logic [WIDTH-1:0] w_max_nxt;
  logic [7:0]       w_iter_inc;

  // Matrix bit row*N+col is simply {row,col} because N is a power of two.
  assign w_col_nxt    = r_col + LN'(1);
  assign w_elig_first = r_adj[{r_row, {LN{1'b0}}}] && (r_row != '0);
  assign w_elig_nxt   = r_adj[{r_row, w_col_nxt}] && (w_col_nxt != r_row);
  assign w_last_col   = (r_col == LAST_IDX);
  assign w_last_row   = (r_row == LAST_IDX);
  assign w_max_nxt    = (delta > r_max) ? delta : r_max;
  assign w_iter_inc   = r_iter + 8'd1;

  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_conv;
  assign row_idx    = r_row;
  assign col_idx    = r_col;
  assign acc_clr    = r_acc_clr;
  assign mac_req    = r_mac_req;
  assign commit     = r_commit;
  assign iter_count = r_iter;

  // Scheduler FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_adj     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_iter    <= '0;
      r_max     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_conv    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_mac_req <= 1'b0;
      r_commit  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_adj     <= adjacency;
            r_row     <= '0;
            r_col     <= '0;
            r_iter    <= '0;
            r_max     <= '0;
            r_conv    <= 1'b0;
            r_busy    <= 1'b1;
            r_acc_clr <= 1'b1;
            r_state   <= CLEAR;
          end
        end
        CLEAR: begin
          r_acc_clr <= 1'b0;
          r_col     <= '0;
          r_mac_req <= w_elig_first;
          r_state   <= SCAN;
        end
        SCAN: begin
          // An ineligible column advances at once; an eligible one waits for its ack.
          if (!r_mac_req || mac_ack) begin
            if (w_last_col) begin
              r_mac_req <= 1'b0;
              r_commit  <= 1'b1;
              r_state   <= COMMIT;
            end else begin
              r_col     <= w_col_nxt;
              r_mac_req <= w_elig_nxt;
            end
          end
        end
        COMMIT: begin
          r_commit <= 1'b0;
          r_max    <= w_max_nxt;
          if (w_last_row) begin
            r_state <= CHECK;
          end else begin
            r_row     <= r_row + LN'(1);
            r_col     <= '0;
            r_acc_clr <= 1'b1;
            r_state   <= CLEAR;
          end
        end
        CHECK: begin
          r_iter <= w_iter_inc;
          if (r_max <= EPS) begin
            r_conv  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (w_iter_inc == ITER_LIM) begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_max     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_acc_clr <= 1'b1;
            r_state   <= CLEAR;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pagerank_sched.md
PAGERANK_SCHED -- requirements
Module: pagerank_sched

Interface
REQ-001 SHALL have parameter N, default 16, number of graph nodes (power of 2, 2..64).
REQ-002 SHALL have parameter WIDTH, default 16, fixed-point value width.
REQ-003 SHALL have parameter MAX_ITER, default 32, iteration limit (1..255).
REQ-004 SHALL have parameter EPS, default 16'h0010, convergence threshold on per-node delta.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request to begin a ranking run.
REQ-008 SHALL have port adjacency  input  N*N  matrix; bit row*N+col set means col contributes to row.
REQ-009 SHALL have port mac_ack  input  1  datapath accepted the current mac_req.
REQ-010 SHALL have port delta  input  WIDTH  |new-old| of the row being committed, from the datapath.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-013 SHALL have port converged  output  1  last run ended on EPS, not on MAX_ITER.
REQ-014 SHALL have port row_idx  output  log2(N)  node being updated.
REQ-015 SHALL have port col_idx  output  log2(N)  contributing node for the current mac_req.
REQ-016 SHALL have port acc_clr  output  1  one-cycle pulse: datapath loads accumulator with d/N.
REQ-017 SHALL have port mac_req  output  1  request one multiply-accumulate of node col_idx into row_idx.
REQ-018 SHALL have port commit  output  1  one-cycle pulse: datapath writes accumulator to node row_idx.
REQ-019 SHALL have port iter_count  output  8  completed iterations in current/last run.

Function
REQ-020 SHALL implement states IDLE, CLEAR, SCAN, COMMIT, CHECK, FIN.
REQ-021 SHALL, in IDLE on start=1, latch adjacency into an internal copy, zero row_idx, iter_count, max-delta register and converged, and go to CLEAR.
REQ-022 SHALL ignore start in every state other than IDLE; adjacency changes after the latch SHALL have no effect.
REQ-023 SHALL, in CLEAR, assert acc_clr for exactly one cycle, set col_idx=0, and go to SCAN.
REQ-024 SHALL, in SCAN, treat col eligible when latched bit row*N+col is 1 and col!=row.
REQ-025 SHALL, for an eligible col, hold mac_req=1 with stable row_idx/col_idx until mac_ack=1; col advances in the cycle after the ack cycle.
REQ-026 SHALL skip an ineligible col in one cycle with mac_req=0.
REQ-027 SHALL go to COMMIT after col N-1 is ack'd or skipped; a row with no eligible col SHALL still commit (value d/N).
REQ-028 SHALL ignore mac_ack when mac_req=0.
REQ-029 SHALL, in COMMIT, pulse commit for one cycle, sample delta that cycle, update max-delta=max(max-delta,delta); if row_idx=N-1 go to CHECK, else increment row_idx and go to CLEAR.
REQ-030 SHALL, in CHECK, increment iter_count; if max-delta<=EPS set converged=1 and go to FIN; else if new iter_count=MAX_ITER go to FIN with converged=0; else clear max-delta, set row_idx=0, go to CLEAR.
REQ-031 SHALL, in FIN, pulse done for one cycle and return to IDLE; converged and iter_count hold until next start.
REQ-032 SHALL drive busy=1 in all states except IDLE; done is asserted with busy=1.
REQ-033 SHALL compare delta as unsigned WIDTH-bit; max-delta SHALL be WIDTH bits with no overflow.

Reset
REQ-034 SHALL, on reset, force IDLE, busy=0, done=0, converged=0, acc_clr=0, mac_req=0, commit=0, row_idx=0, col_idx=0, iter_count=0, max-delta=0, immediately and asynchronously, including mid-run.
REQ-035 SHALL resume normal operation at the first rising edge after reset deasserts, requiring a new start.

Verification
REQ-036 N=4, ring adjacency (row r fed by r-1 mod 4), mac_ack always 1, delta=0 -> per row: acc_clr, 1 mac_req, commit; done after 1 iteration, converged=1, iter_count=1.
REQ-037 N=4, full adjacency, mac_ack delayed 2 cycles each, delta=16'h0100 -> 3 mac_req per row, each held 3 cycles; run ends at MAX_ITER, converged=0, iter_count=MAX_ITER.
REQ-038 Adjacency all zero -> no mac_req; N commits per iteration; delta=0 gives converged=1 after 1 iteration.
REQ-039 Diagonal-only adjacency -> self-loops skipped, mac_req never asserted.
REQ-040 start pulsed while busy and adjacency changed mid-run -> no restart, sequence matches latched matrix.
REQ-041 reset asserted during SCAN with mac_req=1 -> all outputs to REQ-034 values same cycle; fresh start runs a complete correct sequence.
